// File: rtl/mul_div_unit_if.sv
// ============================================================================
// Module      : mul_div_unit_if
// Description : Issue/result bundle between the execute-stage control and the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_div_unit_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, rs_data, rt_data, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mdu_op, rs_data, rt_data, cancel,
        output busy, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle multiply/divide unit holding the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mul_div_unit_if.slave   mdu
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [63:0]       temp_q,  temp_d;
    logic              wr_q,    wr_d;
    logic [31:0]       hi_q,    hi_d;
    logic [31:0]       lo_q,    lo_d;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quo_s, w_rem_s, w_quo_u, w_rem_u;
    logic        w_div_zero, w_div_ovf, w_issue;

    assign w_prod_s   = 64'($signed(mdu.rs_data)) * 64'($signed(mdu.rt_data));
    assign w_prod_u   = {32'd0, mdu.rs_data} * {32'd0, mdu.rt_data};
    assign w_div_zero = (mdu.rt_data == 32'd0);
    assign w_div_ovf  = (mdu.rs_data == 32'h8000_0000) && (mdu.rt_data == 32'hFFFF_FFFF);
    assign w_issue    = mdu.start && !mdu.cancel;

    // The one signed quotient that overflows 32 bits is pinned to its wrapped value.
    always_comb begin
        w_quo_s = 32'd0;
        w_rem_s = 32'd0;
        w_quo_u = 32'd0;
        w_rem_u = 32'd0;
        if (w_div_ovf) begin
            w_quo_s = 32'h8000_0000;
        end else if (!w_div_zero) begin
            w_quo_s = $signed(mdu.rs_data) / $signed(mdu.rt_data);
            w_rem_s = $signed(mdu.rs_data) % $signed(mdu.rt_data);
        end
        if (!w_div_zero) begin
            w_quo_u = mdu.rs_data / mdu.rt_data;
            w_rem_u = mdu.rs_data % mdu.rt_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_issue) begin
                    unique case (mdu.mdu_op)
                        OP_MULT: begin
                            temp_d = w_prod_s; wr_d = 1'b1;
                            cnt_d = C_MULT_CNT; state_d = S_BUSY;
                        end
                        OP_MULTU: begin
                            temp_d = w_prod_u; wr_d = 1'b1;
                            cnt_d = C_MULT_CNT; state_d = S_BUSY;
                        end
                        OP_DIV: begin
                            temp_d = {w_rem_s, w_quo_s}; wr_d = !w_div_zero;
                            cnt_d = C_DIV_CNT; state_d = S_BUSY;
                        end
                        OP_DIVU: begin
                            temp_d = {w_rem_u, w_quo_u}; wr_d = !w_div_zero;
                            cnt_d = C_DIV_CNT; state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = mdu.rs_data;
                        OP_MTLO: lo_d = mdu.rs_data;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (mdu.cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (wr_q) begin
                        hi_d = temp_q[63:32];
                        lo_d = temp_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            temp_q  <= '0;
            wr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdu.busy = (state_q == S_BUSY);
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Scoreboard bench for mul_div_unit with an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_div_unit_if bus ();

    mul_div_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    typedef struct {
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;
    logic        mon_prev = 1'b0;
    int          mon_cnt  = 0;
    exp_t        mon_e;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 64-bit integer arithmetic; returns {write, hi, lo}.
    function automatic logic [64:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); return {1'b1, p}; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; return {1'b1, p}; end
            3'd3: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                return {1'b1, a % b, a / b};
            end
            default: return {1'b0, 64'd0};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.cancel  = 1'b0;
        bus.mdu_op  = 3'($urandom_range(0, 7));
        bus.rs_data = 32'($urandom);
        bus.rt_data = 32'($urandom);
    endtask

    // Single-cycle ops (mthi/mtlo/none/reserved), optionally with cancel asserted.
    task automatic issue_simple(input logic [2:0] op, input logic [31:0] a, input logic cncl);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mdu_op = op; bus.rs_data = a;
        bus.rt_data = 32'($urandom); bus.cancel = cncl;
        @(posedge clk); #1;
        idle_inputs();
        if (!cncl && op == 3'd5) m_hi = a;
        if (!cncl && op == 3'd6) m_lo = a;
        check32("simple_busy", 32'(bus.busy), 32'd0);
        check32("simple_hi", bus.hi, m_hi);
        check32("simple_lo", bus.lo, m_lo);
    endtask

    // disturb: 1 mult start at busy cycle 2, 2 mtlo at cycle 3, 3 mult start on the last cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input int disturb, input int reset_at);
        logic [64:0] r;
        exp_t        e;
        int          n;
        int          j;
        bit          done;
        r = ref_result(op, a, b);
        n = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
        e.pre_hi = m_hi;
        e.pre_lo = m_lo;
        if (reset_at > 0) begin
            e.exp_hi = 32'd0; e.exp_lo = 32'd0; e.cycles = reset_at;
        end else if (cancel_at > 0) begin
            e.exp_hi = m_hi; e.exp_lo = m_lo; e.cycles = cancel_at;
        end else begin
            e.exp_hi = r[64] ? r[63:32] : m_hi;
            e.exp_lo = r[64] ? r[31:0]  : m_lo;
            e.cycles = n;
        end
        sb_q.push_back(e);
        m_hi = e.exp_hi;
        m_lo = e.exp_lo;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mdu_op = op; bus.rs_data = a; bus.rt_data = b; bus.cancel = 1'b0;
        done = 1'b0;
        for (j = 1; j <= 40 && !done; j++) begin
            @(posedge clk) ; #0;
            #1;
            idle_inputs();
            if (j > 1 && bus.busy !== 1'b1) begin
                done = 1'b1;
            end else begin
                bus.cancel = (cancel_at == j);
                if ((disturb == 1 && j == 2) || (disturb == 3 && j == n)) begin
                    bus.start = 1'b1; bus.mdu_op = 3'd1;
                end else if (disturb == 2 && j == 3) begin
                    bus.start = 1'b1; bus.mdu_op = 3'd6;
                end
                if (reset_at == j) begin
                    @(negedge clk); #1;
                    reset = 1'b0;
                    #1;
                    check32("async_rst_busy", 32'(bus.busy), 32'd0);
                    check32("async_rst_hi", bus.hi, 32'd0);
                    check32("async_rst_lo", bus.lo, 32'd0);
                    @(posedge clk); #1;
                    reset = 1'b1;
                    idle_inputs();
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: busy still %0b, required 0 within 40 cycles", bus.busy);
        end
        idle_inputs();
    endtask

    // Monitor: counts busy cycles, checks HI/LO hold during busy and the result at busy fall.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                mon_cnt++;
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL busy_unexpected: got busy=1 required no op in flight");
                end else begin
                    check32("hold_hi", bus.hi, sb_q[0].pre_hi);
                    check32("hold_lo", bus.lo, sb_q[0].pre_lo);
                end
            end else if (mon_prev) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_unexpected: got completion required none");
                end else begin
                    mon_e = sb_q.pop_front();
                    check32("done_hi", bus.hi, mon_e.exp_hi);
                    check32("done_lo", bus.lo, mon_e.exp_lo);
                    check32("busy_cycles", 32'(mon_cnt), 32'(mon_e.cycles));
                end
                mon_cnt = 0;
            end
            mon_prev = (bus.busy === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          mode;
        idle_inputs();
        #12;
        check32("reset_busy", 32'(bus.busy), 32'd0);
        check32("reset_hi", bus.hi, 32'd0);
        check32("reset_lo", bus.lo, 32'd0);
        @(negedge clk); reset = 1'b1;

        issue(3'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
        check32("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check32("mult_lo", bus.lo, 32'hFFFF_FFF1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        check32("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check32("multu_lo", bus.lo, 32'h0000_0001);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        check32("div_hi", bus.hi, 32'hFFFF_FFFF);
        check32("div_lo", bus.lo, 32'hFFFF_FFFD);
        issue(3'd4, 32'd7, 32'd2, 0, 0, 0);
        check32("divu_hi", bus.hi, 32'd1);
        check32("divu_lo", bus.lo, 32'd3);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        check32("div_ovf_hi", bus.hi, 32'd0);
        check32("div_ovf_lo", bus.lo, 32'h8000_0000);

        issue_simple(3'd5, 32'h0000_1234, 1'b0);
        issue(3'd4, 32'd99, 32'd0, 0, 0, 0);
        check32("divz_hi", bus.hi, 32'h0000_1234);
        check32("divz_lo", bus.lo, 32'h8000_0000);

        issue(3'd3, 32'd100, 32'd7, 0, 1, 0);
        issue(3'd4, 32'd1000, 32'd9, 0, 2, 0);
        issue(3'd1, 32'd12, 32'd13, 0, 3, 0);
        issue(3'd1, 32'd6, 32'd7, 0, 0, 3);
        issue(3'd3, 32'd50, 32'd3, 2, 0, 0);
        issue(3'd2, 32'd50, 32'd3, MULT_CYCLES, 0, 0);

        issue_simple(3'd6, 32'hA5A5_0001, 1'b1);
        issue_simple(3'd0, 32'h1111_2222, 1'b0);
        issue_simple(3'd7, 32'h3333_4444, 1'b0);
        issue_simple(3'd6, 32'h5555_6666, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(1, 6));
            a    = pick();
            b    = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            mode = $urandom_range(0, 5);
            if (op >= 3'd5) begin
                issue_simple(op, a, ($urandom_range(0, 5) == 0));
            end else if (mode == 2) begin
                issue(op, a, b, $urandom_range(1, (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES), 0, 0);
            end else if (mode == 3) begin
                issue(op, a, b, 0, $urandom_range(1, 3), 0);
            end else begin
                issue(op, a, b, 0, 0, 0);
            end
        end

        repeat (3) @(posedge clk);
        check32("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
